// File: rtl/regfile_mpwb.sv
// Multi-port integer register file: NUM_RD combinational reads, two writeback ports,
// x0 hard-wired to zero, optional write->read bypass and a post-reset clear sweep.
module regfile_mpwb #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int NUM_RD  = 2,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     ready_o,
  input  logic [NUM_RD*$clog2(REG_NUM)-1:0] rs_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rs_data_o,
  input  logic                     w0_we_i,
  input  logic [$clog2(REG_NUM)-1:0] w0_addr_i,
  input  logic [XLEN-1:0]          w0_data_i,
  input  logic                     w1_we_i,
  input  logic [$clog2(REG_NUM)-1:0] w1_addr_i,
  input  logic [XLEN-1:0]          w1_data_i
);

  localparam int AW = $clog2(REG_NUM);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr_we;
  logic            w0_hit, w1_hit;
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] mem_q [REG_NUM];

  assign ready_o = (state_q == RUN);
  assign w0_hit  = ready_o && w0_we_i && (w0_addr_i != '0);
  assign w1_hit  = ready_o && w1_we_i && (w1_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = !rst_i;
        idx_d  = idx_q + AW'(1);
        if (idx_q == AW'(REG_NUM - 1)) state_d = RUN;
      end
      default: ;
    endcase
  end

  // No reset on the array so it can map to distributed RAM; the sweep clears it.
  // Clear and writeback never overlap since writes require ready_o; w1 is last so it wins.
  always_ff @(posedge clk_i) begin
    if (clr_we) mem_q[idx_q] <= '0;
    if (w0_hit) mem_q[w0_addr_i] <= w0_data_i;
    if (w1_hit) mem_q[w1_addr_i] <= w1_data_i;
  end

  always_comb begin
    rs_data_o = '0;
    ra        = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rs_addr_i[k*AW +: AW];
      if (ready_o && (ra != '0)) begin
        if (BYPASS && w1_hit && (w1_addr_i == ra))
          rs_data_o[k*XLEN +: XLEN] = w1_data_i;
        else if (BYPASS && w0_hit && (w0_addr_i == ra))
          rs_data_o[k*XLEN +: XLEN] = w0_data_i;
        else
          rs_data_o[k*XLEN +: XLEN] = mem_q[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mpwb.sv
// Scoreboard bench for regfile_mpwb: bypassing and non-bypassing instances share stimulus;
// expectations are queued by the stimulus and checked at the falling edge by a monitor.
module tb_regfile_mpwb;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [9:0]  rs_addr = '0;
  logic        w0_we = 1'b0, w1_we = 1'b0;
  logic [4:0]  w0_addr = '0, w1_addr = '0;
  logic [31:0] w0_data = '0, w1_data = '0;
  logic        rdy_b, rdy_n;
  logic [63:0] rd_b, rd_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mpwb #(.XLEN(32), .REG_NUM(32), .NUM_RD(2), .BYPASS(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .ready_o(rdy_b),
    .rs_addr_i(rs_addr), .rs_data_o(rd_b),
    .w0_we_i(w0_we), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
    .w1_we_i(w1_we), .w1_addr_i(w1_addr), .w1_data_i(w1_data)
  );

  regfile_mpwb #(.XLEN(32), .REG_NUM(32), .NUM_RD(2), .BYPASS(1'b0)) dut_nb (
    .clk_i(clk), .rst_i(rst_i), .ready_o(rdy_n),
    .rs_addr_i(rs_addr), .rs_data_o(rd_n),
    .w0_we_i(w0_we), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
    .w1_we_i(w1_we), .w1_addr_i(w1_addr), .w1_data_i(w1_data)
  );

  // sel: 0/1 ready (bypass/no-bypass), 2/3 bypass ports 0/1, 4/5 no-bypass ports 0/1
  function automatic logic [31:0] observe(int sel);
    case (sel)
      0: return {31'd0, rdy_b};
      1: return {31'd0, rdy_n};
      2: return rd_b[31:0];
      3: return rd_b[63:32];
      4: return rd_n[31:0];
      default: return rd_n[63:32];
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = observe(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s sel=%0d got=%h expected=%h t=%0t", e.name, e.sel, act, e.exp, $time);
      end
    end
  end

  task automatic expect_v(string name, int sel, logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_rdy(string name, logic v);
    expect_v(name, 0, {31'd0, v});
    expect_v(name, 1, {31'd0, v});
  endtask

  // both instances, both ports, bypass and no-bypass expectations
  task automatic expect_rd(string name, logic [31:0] b0, logic [31:0] b1,
                           logic [31:0] n0, logic [31:0] n1);
    expect_v(name, 2, b0); expect_v(name, 3, b1);
    expect_v(name, 4, n0); expect_v(name, 5, n1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(logic [4:0] a0, logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic read_all_zero(string name);
    for (int r = 0; r < 32; r++) begin
      set_rd(5'(r), 5'(31 - r));
      expect_rd(name, 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and clear sweep
    rst_i = 1'b1;
    tick();
    tick();
    expect_rdy("reset_ready", 1'b0);
    expect_rd("reset_data", 32'd0, 32'd0, 32'd0, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 31; i++) begin
      expect_rdy("sweep_ready_low", 1'b0);
      tick();
    end
    expect_rdy("sweep_ready_high", 1'b1);
    read_all_zero("after_sweep_zero");

    // 2: write/read via w0
    w0_we = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd0);
    expect_rd("w0_same_cycle", 32'hDEADBEEF, 32'd0, 32'd0, 32'd0);
    tick();
    w0_we = 1'b0;
    expect_rd("w0_next_cycle", 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd0);
    tick();

    // 3: x0 write dropped and not forwarded
    w0_we = 1'b1; w0_addr = 5'd0; w0_data = 32'h1234;
    set_rd(5'd0, 5'd0);
    expect_rd("x0_same", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    w0_we = 1'b0;
    expect_rd("x0_next", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // 4: collision, w1 wins
    w0_we = 1'b1; w0_addr = 5'd7; w0_data = 32'h11;
    w1_we = 1'b1; w1_addr = 5'd7; w1_data = 32'h22;
    set_rd(5'd7, 5'd7);
    expect_rd("collide_bypass", 32'h22, 32'h22, 32'd0, 32'd0);
    tick();
    w0_we = 1'b0; w1_we = 1'b0;
    expect_rd("collide_stored", 32'h22, 32'h22, 32'h22, 32'h22);
    tick();

    // 5: w1 bypass on port1, w0 bypass on port0 to a different register
    w1_we = 1'b1; w1_addr = 5'd3; w1_data = 32'hA5A5;
    w0_we = 1'b1; w0_addr = 5'd9; w0_data = 32'h77;
    set_rd(5'd9, 5'd3);
    expect_rd("bypass_same", 32'h77, 32'hA5A5, 32'd0, 32'd0);
    tick();
    w0_we = 1'b0; w1_we = 1'b0;
    expect_rd("bypass_next", 32'h77, 32'hA5A5, 32'h77, 32'hA5A5);
    tick();
    set_rd(5'd5, 5'd7);
    expect_rd("retained", 32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 32'h22);
    tick();

    // 6: reset in RUN, then reset again at sweep cycle 10, writes attempted throughout
    rst_i = 1'b1;
    w0_we = 1'b1; w0_addr = 5'd5; w0_data = 32'hFFFF0000;
    w1_we = 1'b1; w1_addr = 5'd3; w1_data = 32'h0BAD0BAD;
    set_rd(5'd5, 5'd3);
    expect_rdy("run_rst_ready_before", 1'b1);
    tick();
    expect_rdy("run_rst_ready", 1'b0);
    expect_rd("run_rst_data", 32'd0, 32'd0, 32'd0, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_rdy("mid_sweep_ready", 1'b0);
      expect_rd("mid_sweep_data", 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 31; i++) begin
      expect_rdy("resweep_ready_low", 1'b0);
      expect_rd("resweep_data", 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
    end
    w0_we = 1'b0; w1_we = 1'b0;
    expect_rdy("resweep_ready_high", 1'b1);
    read_all_zero("after_resweep_zero");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
